hazard_ctrl: RTL

//  Parametrised hazard/forwarding controller for the 5-stage pipelined RV32 core (F/D/E/M/W).
//  - Tracks E/M/W-stage destination metadata in its own shift registers.
//  - Generates load-use and RAW stalls, branch/jump flushes and ALU operand-forwarding selects.
//  - Adds a multi-cycle memory-wait freeze and saturating stall/flush counters.
//  - Sits beside the pipeline registers and drives their enable/clear inputs.

---
 rtl/hazard_ctrl_pkg.sv | 37 +++
 rtl/hazard_ctrl_if.sv | 36 +++
 rtl/hazard_ctrl_stage_meta_reg.sv | 20 ++
 rtl/hazard_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the RV32 hazard/forwarding controller.
// Metadata rd fields are REG_W bits wide; keep REG_ADDR_W <= REG_W.
package hazard_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regWrite;
        logic             load;
        logic             mem;
    } stage_meta_t;

    localparam logic [0:0] MEM_IDLE = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    // x0 is hardwired, so a write to it can never be a producer.
    function automatic logic hazMatch(stage_meta_t s, logic [REG_W-1:0] rs, logic useRs);
        return s.valid & s.regWrite & (s.rd != '0) & (s.rd == rs) & useRs;
    endfunction

    // M is the younger producer, so it wins over W.
    function automatic fwd_sel_t fwdSel(stage_meta_t mS, stage_meta_t wS,
                                        logic [REG_W-1:0] rs, logic useRs);
        if (hazMatch(mS, rs, useRs)) return FWD_M;
        if (hazMatch(wS, rs, useRs)) return FWD_W;
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side request and pipeline-control response bundle of the hazard controller.
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  validD;
    logic [REG_ADDR_W-1:0] rs1D;
    logic [REG_ADDR_W-1:0] rs2D;
    logic                  useRs1D;
    logic                  useRs2D;
    logic [REG_ADDR_W-1:0] rdD;
    logic                  regWriteD;
    logic                  loadD;
    logic                  memD;
    logic                  redirectE;

    logic                  stallF;
    logic                  stallD;
    logic                  flushD;
    logic                  flushE;
    logic                  freeze;
    logic [1:0]            fwdAE;
    logic [1:0]            fwdBE;
    logic [CNT_W-1:0]      stallCnt;
    logic [CNT_W-1:0]      flushCnt;

    modport master (
        output validD, rs1D, rs2D, useRs1D, useRs2D, rdD, regWriteD, loadD, memD, redirectE,
        input  stallF, stallD, flushD, flushE, freeze, fwdAE, fwdBE, stallCnt, flushCnt
    );

    modport slave (
        input  validD, rs1D, rs2D, useRs1D, useRs2D, rdD, regWriteD, loadD, memD, redirectE,
        output stallF, stallD, flushD, flushE, freeze, fwdAE, fwdBE, stallCnt, flushCnt
    );
endinterface

// File: rtl/hazard_ctrl_stage_meta_reg.sv
// One pipeline stage of destination metadata with hold (priority) and bubble controls.
module stage_meta_reg
    import hazard_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        bubble,
    input  stage_meta_t din,
    output stage_meta_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (!hold)
            q <= bubble ? '0 : din;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage RV32 pipe: stalls, flushes,
// operand-forward selects, memory-wait freeze and saturating perf counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int FORWARD     = 1,
    parameter int WRITE_FIRST = 1,
    parameter int MEM_LAT     = 1,
    parameter int CNT_W       = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    stage_meta_t [2:0]     meta;     // 0:E 1:M 2:W
    stage_meta_t [2:0]     metaIn;
    logic        [2:0]     bubble;
    logic [REG_ADDR_W-1:0] rdDIdx;
    logic [REG_W-1:0]      rs1D, rs2D, rs1E, rs2E;
    logic                  useRs1E, useRs2E;
    logic                  freeze, hazStall, redirect, memEnter, stallD, flush;
    logic                  hitE, hitM, hitW;
    logic [0:0]            memState;
    logic [LAT_W-1:0]      waitCnt;
    logic                  unusedMeta;

    assign rdDIdx   = hz.rdD;
    assign rs1D     = REG_W'(hz.rs1D);
    assign rs2D     = REG_W'(hz.rs2D);
    assign redirect = hz.redirectE;

    assign metaIn[0] = '{valid: hz.validD, rd: REG_W'(rdDIdx), regWrite: hz.regWriteD,
                         load: hz.loadD, mem: hz.memD};
    assign bubble    = {2'b00, redirect | hazStall};

    for (genvar i = 0; i < 3; i++) begin : gStage
        if (i > 0) begin : gLink
            assign metaIn[i] = meta[i-1];
        end
        stage_meta_reg uReg (
            .clk    (clk),
            .rst_n  (rst_n),
            .hold   (freeze),
            .bubble (bubble[i]),
            .din    (metaIn[i]),
            .q      (meta[i])
        );
    end

    // E also keeps its source operands so forwarding can be selected in E.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1E <= '0; rs2E <= '0; useRs1E <= 1'b0; useRs2E <= 1'b0;
        end else if (!freeze) begin
            if (bubble[0]) begin
                rs1E <= '0; rs2E <= '0; useRs1E <= 1'b0; useRs2E <= 1'b0;
            end else begin
                rs1E <= rs1D; rs2E <= rs2D; useRs1E <= hz.useRs1D; useRs2E <= hz.useRs2D;
            end
        end
    end

    assign hitE = hazMatch(meta[0], rs1D, hz.useRs1D) | hazMatch(meta[0], rs2D, hz.useRs2D);
    assign hitM = hazMatch(meta[1], rs1D, hz.useRs1D) | hazMatch(meta[1], rs2D, hz.useRs2D);
    assign hitW = hazMatch(meta[2], rs1D, hz.useRs1D) | hazMatch(meta[2], rs2D, hz.useRs2D);

    // With forwarding only a load in E cannot be bypassed in time.
    assign hazStall = (FORWARD != 0) ? (hitE & meta[0].load)
                                     : (hitE | hitM | ((WRITE_FIRST == 0) & hitW));

    assign freeze   = (memState == MEM_WAIT) && (waitCnt != '0);
    assign memEnter = (MEM_LAT > 1) && !freeze && meta[0].valid && meta[0].mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memState <= MEM_IDLE;
            waitCnt  <= '0;
        end else if (freeze) begin
            waitCnt  <= waitCnt - 1'b1;
        end else if (memEnter) begin
            memState <= MEM_WAIT;
            waitCnt  <= LAT_W'(MEM_LAT - 1);
        end else begin
            memState <= MEM_IDLE;
        end
    end

    assign stallD = freeze | (hazStall & !redirect);
    assign flush  = redirect & !freeze & rst_n;

    assign hz.stallD = stallD;
    assign hz.stallF = stallD;
    assign hz.flushD = flush;
    assign hz.flushE = flush;
    assign hz.freeze = freeze;
    assign hz.fwdAE  = (FORWARD != 0) ? fwdSel(meta[1], meta[2], rs1E, useRs1E) : FWD_NONE;
    assign hz.fwdBE  = (FORWARD != 0) ? fwdSel(meta[1], meta[2], rs2E, useRs2E) : FWD_NONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hz.stallCnt <= '0;
            hz.flushCnt <= '0;
        end else begin
            if (stallD && hz.stallCnt != '1) hz.stallCnt <= hz.stallCnt + 1'b1;
            if (flush && hz.flushCnt != '1)  hz.flushCnt <= hz.flushCnt + 1'b1;
        end
    end

    assign unusedMeta = ^{meta[1].load, meta[1].mem, meta[2].load, meta[2].mem};

endmodule
